// File: rtl/noc_flat_ep_bridge.sv
// rtl/noc_flat_ep_bridge.sv - NE-lane endpoint bridge: credit-based flit injection and per-VC ejection FIFOs
module noc_flat_ep_bridge #(
    parameter int NE     = 4,
    parameter int V      = 2,
    parameter int Fw     = 36,
    parameter int B      = 4,
    parameter int VC_LSB = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NE*Fw-1:0] inj_flit_all,
    input  logic [NE-1:0]    inj_valid_all,
    output logic [NE-1:0]    inj_ready_all,
    output logic [NE*Fw-1:0] flit_out_all,
    output logic [NE-1:0]    flit_out_wr_all,
    input  logic [NE*V-1:0]  credit_in_all,
    input  logic [NE*Fw-1:0] flit_in_all,
    input  logic [NE-1:0]    flit_in_wr_all,
    output logic [NE*V-1:0]  credit_out_all,
    output logic [NE*Fw-1:0] ej_flit_all,
    output logic [NE-1:0]    ej_valid_all,
    input  logic [NE-1:0]    ej_ready_all,
    output logic [NE-1:0]    err_all
);
    localparam int CW = $clog2(B + 1);
    localparam int PW = (B > 1) ? $clog2(B) : 1;
    localparam int VW = (V > 1) ? $clog2(V) : 1;
    localparam logic [V-1:0] VONE = V'(1);

    function automatic logic is_onehot(input logic [V-1:0] x);
        return (x != '0) && ((x & (x - VONE)) == '0);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(B - 1)) ? '0 : p + PW'(1);
    endfunction

    for (genvar i = 0; i < NE; i++) begin : g_lane
        logic [Fw-1:0] in_flit, fi;
        logic [V-1:0]  in_vc, fvc, cr, cnt_nz, ovf, nonempty, pop_vec, push_vec;
        logic          inj_ok, accept, found, pop, drop;
        logic [VW-1:0] win, rr_q, rr_d;
        logic [CW-1:0] cnt_q [V];
        logic [CW-1:0] cnt_d [V];
        logic [CW-1:0] occ_q [V];
        logic [PW-1:0] wp_q [V];
        logic [PW-1:0] rp_q [V];
        logic [Fw-1:0] mem_q [V][B];
        logic [Fw-1:0] flit_out_q;
        logic          wr_q, err_q, err_d;
        logic [V-1:0]  credit_out_q;

        assign in_flit = inj_flit_all[Fw*i +: Fw];
        assign in_vc   = in_flit[VC_LSB +: V];
        assign fi      = flit_in_all[Fw*i +: Fw];
        assign fvc     = fi[VC_LSB +: V];
        assign cr      = credit_in_all[V*i +: V];

        always_comb begin
            for (int v = 0; v < V; v++) begin
                cnt_nz[v]   = (cnt_q[v] != '0);
                nonempty[v] = (occ_q[v] != '0);
            end
        end

        // Ready only needs the credit bit of the (one-hot) selected VC
        assign inj_ok = is_onehot(in_vc) && |(in_vc & cnt_nz);
        assign accept = inj_valid_all[i] && inj_ok;

        always_comb begin
            for (int v = 0; v < V; v++) begin
                cnt_d[v] = cnt_q[v];
                ovf[v]   = 1'b0;
                if (cr[v] && !(accept && in_vc[v])) begin
                    if (cnt_q[v] == CW'(B)) ovf[v] = 1'b1;
                    else                    cnt_d[v] = cnt_q[v] + CW'(1);
                end else if (!cr[v] && accept && in_vc[v]) begin
                    cnt_d[v] = cnt_q[v] - CW'(1);
                end
            end
        end

        // Round-robin: first non-empty VC at or after the pointer
        always_comb begin
            win   = rr_q;
            found = 1'b0;
            for (int k = 0; k < V; k++) begin
                int idx;
                idx = int'(rr_q) + k;
                if (idx >= V) idx = idx - V;
                if (!found && nonempty[idx]) begin
                    win   = VW'(idx);
                    found = 1'b1;
                end
            end
        end

        assign pop = found && ej_ready_all[i];

        always_comb begin
            for (int v = 0; v < V; v++) begin
                pop_vec[v]  = pop && (win == VW'(v));
                push_vec[v] = flit_in_wr_all[i] && is_onehot(fvc) && fvc[v] &&
                              ((occ_q[v] != CW'(B)) || pop_vec[v]);
            end
        end

        assign drop  = flit_in_wr_all[i] && !(|push_vec);
        assign err_d = err_q || (inj_valid_all[i] && !is_onehot(in_vc)) || (|ovf) || drop;
        assign rr_d  = !pop ? rr_q : ((win == VW'(V - 1)) ? '0 : win + VW'(1));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int v = 0; v < V; v++) begin
                    cnt_q[v] <= CW'(B);
                    occ_q[v] <= '0;
                    wp_q[v]  <= '0;
                    rp_q[v]  <= '0;
                end
                flit_out_q   <= '0;
                wr_q         <= 1'b0;
                credit_out_q <= '0;
                rr_q         <= '0;
                err_q        <= 1'b0;
            end else begin
                for (int v = 0; v < V; v++) begin
                    cnt_q[v] <= cnt_d[v];
                    if (push_vec[v]) wp_q[v] <= ptr_inc(wp_q[v]);
                    if (pop_vec[v])  rp_q[v] <= ptr_inc(rp_q[v]);
                    if (push_vec[v] && !pop_vec[v])      occ_q[v] <= occ_q[v] + CW'(1);
                    else if (!push_vec[v] && pop_vec[v]) occ_q[v] <= occ_q[v] - CW'(1);
                end
                if (accept) flit_out_q <= in_flit;
                wr_q         <= accept;
                credit_out_q <= pop_vec;
                rr_q         <= rr_d;
                err_q        <= err_d;
            end
        end

        // Payload storage carries no reset; occupancy alone defines validity
        always_ff @(posedge clk) begin
            for (int v = 0; v < V; v++) begin
                if (push_vec[v]) mem_q[v][wp_q[v]] <= fi;
            end
        end

        assign inj_ready_all[i]          = inj_ok;
        assign flit_out_all[Fw*i +: Fw]  = flit_out_q;
        assign flit_out_wr_all[i]        = wr_q;
        assign credit_out_all[V*i +: V]  = credit_out_q;
        assign ej_valid_all[i]           = found;
        assign ej_flit_all[Fw*i +: Fw]   = found ? mem_q[win][rp_q[win]] : '0;
        assign err_all[i]                = err_q;
    end
endmodule

// File: tb/tb_noc_flat_ep_bridge.sv
// tb/tb_noc_flat_ep_bridge.sv - scoreboard bench for noc_flat_ep_bridge
module tb_noc_flat_ep_bridge;
    logic         clk = 1'b0;
    logic         reset;
    logic [143:0] inj_flit_all, flit_in_all;
    logic [3:0]   inj_valid_all, flit_in_wr_all, ej_ready_all;
    logic [7:0]   credit_in_all;
    logic [3:0]   inj_ready_all, flit_out_wr_all, ej_valid_all, err_all;
    logic [143:0] flit_out_all, ej_flit_all;
    logic [7:0]   credit_out_all;

    noc_flat_ep_bridge dut (
        .clk(clk), .reset(reset),
        .inj_flit_all(inj_flit_all), .inj_valid_all(inj_valid_all), .inj_ready_all(inj_ready_all),
        .flit_out_all(flit_out_all), .flit_out_wr_all(flit_out_wr_all),
        .credit_in_all(credit_in_all), .flit_in_all(flit_in_all), .flit_in_wr_all(flit_in_wr_all),
        .credit_out_all(credit_out_all), .ej_flit_all(ej_flit_all), .ej_valid_all(ej_valid_all),
        .ej_ready_all(ej_ready_all), .err_all(err_all)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mcnt[2];
    int mrr;
    logic merr;
    logic [35:0] last_fo;
    logic [35:0] inj_q[$];
    logic [35:0] efq0[$];
    logic [35:0] efq1[$];
    int n_wr, n_pop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mkf(input logic [1:0] vc, input logic [25:0] pl);
        return {8'h5A, vc, pl};
    endfunction

    function automatic logic oh(input logic [1:0] v);
        return (v == 2'b01) || (v == 2'b10);
    endfunction

    function automatic int vidx(input logic [1:0] v);
        return (v == 2'b10) ? 1 : 0;
    endfunction

    function automatic int qsize(input int v);
        return (v == 0) ? efq0.size() : efq1.size();
    endfunction

    task automatic model_reset();
        mcnt[0] = 4; mcnt[1] = 4; mrr = 0; merr = 1'b0; last_fo = '0;
        inj_q.delete(); efq0.delete(); efq1.delete();
    endtask

    task automatic clear_inputs();
        inj_flit_all = '0; flit_in_all = '0; inj_valid_all = '0; flit_in_wr_all = '0;
        ej_ready_all = '0; credit_in_all = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        #1;
        chk("rst_outputs", {flit_out_wr_all, credit_out_all, ej_valid_all, err_all}, '0);
        chk("rst_flits", {28'd0, (flit_out_all | ej_flit_all)}, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // One clock of lane 0 against the model; lanes 1 and 3 must stay idle
    task automatic step();
        logic [35:0] f, fi, hd;
        logic [1:0]  vc, fv, cred_next;
        logic        exp_rdy, exp_acc, dec, inc;
        int          win, idx;
        #1;
        f = inj_flit_all[35:0];
        vc = f[27:26];
        exp_rdy = oh(vc) && (mcnt[vidx(vc)] > 0);
        exp_acc = inj_valid_all[0] && exp_rdy;
        chk("inj_ready", inj_ready_all[0], exp_rdy);
        if (inj_valid_all[0] && !oh(vc)) merr = 1'b1;
        if (exp_acc) inj_q.push_back(f);
        for (int v = 0; v < 2; v++) begin
            dec = exp_acc && (vidx(vc) == v);
            inc = credit_in_all[v];
            if (inc && !dec) begin
                if (mcnt[v] == 4) merr = 1'b1;
                else mcnt[v]++;
            end else if (dec && !inc) begin
                mcnt[v]--;
            end
        end
        win = -1;
        for (int k = 0; k < 2; k++) begin
            idx = (mrr + k) % 2;
            if (win < 0 && qsize(idx) > 0) win = idx;
        end
        cred_next = 2'b00;
        chk("ej_valid", ej_valid_all[0], win >= 0);
        if (win >= 0) begin
            hd = (win == 0) ? efq0[0] : efq1[0];
            chk("ej_flit", ej_flit_all[35:0], hd);
            if (ej_ready_all[0]) begin
                if (win == 0) void'(efq0.pop_front());
                else void'(efq1.pop_front());
                cred_next[win] = 1'b1;
                mrr = (win + 1) % 2;
            end
        end else begin
            chk("ej_flit_idle", ej_flit_all[35:0], '0);
        end
        if (flit_in_wr_all[0]) begin
            fi = flit_in_all[35:0];
            fv = fi[27:26];
            if (!oh(fv)) merr = 1'b1;
            else if (qsize(vidx(fv)) < 4) begin
                if (vidx(fv) == 0) efq0.push_back(fi);
                else efq1.push_back(fi);
            end else merr = 1'b1;
        end
        @(posedge clk);
        #1;
        credit_in_all = '0;
        flit_in_wr_all = '0;
        if (flit_out_wr_all[0] === 1'b1) n_wr++;
        if (cred_next != 2'b00) n_pop++;
        chk("flit_out_wr", flit_out_wr_all[0], exp_acc);
        if (exp_acc) last_fo = inj_q.pop_front();
        chk("flit_out", flit_out_all[35:0], last_fo);
        chk("credit_out", credit_out_all[1:0], cred_next);
        chk("err", err_all[0], merr);
        chk("idle_lanes", {inj_ready_all[1], inj_ready_all[3], err_all[1], err_all[3],
                           flit_out_wr_all[1], flit_out_wr_all[3], ej_valid_all[1], ej_valid_all[3],
                           credit_out_all[3:2], credit_out_all[7:6]}, '0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        n_wr = 0; n_pop = 0;
        do_reset();

        // Credit exhaustion, then a single returned credit
        inj_valid_all[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            inj_flit_all[35:0] = mkf(2'b01, 26'(k + 1));
            step();
        end
        credit_in_all[0] = 1'b1;
        step();
        inj_flit_all[35:0] = mkf(2'b01, 26'h77);
        step();
        step();
        chk("exhaust_accepts", n_wr, 5);

        // Accept and credit on the same VC at cnt=2
        inj_valid_all[0] = 1'b0;
        credit_in_all[0] = 1'b1; step();
        credit_in_all[0] = 1'b1; step();
        inj_valid_all[0] = 1'b1;
        inj_flit_all[35:0] = mkf(2'b01, 26'h100);
        credit_in_all[0] = 1'b1;
        step();
        n_wr = 0;
        for (int k = 0; k < 4; k++) begin
            inj_flit_all[35:0] = mkf(2'b01, 26'(k + 'h200));
            step();
        end
        chk("simul_remaining", n_wr, 2);

        // Credit saturation at cnt=B
        do_reset();
        credit_in_all[0] = 1'b1;
        step();
        chk("sat_err", err_all[0], 1'b1);
        n_wr = 0;
        inj_valid_all[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            inj_flit_all[35:0] = mkf(2'b01, 26'(k + 'h300));
            step();
        end
        chk("sat_cnt", n_wr, 4);

        // Invalid VC fields
        do_reset();
        inj_valid_all[0] = 1'b1;
        inj_flit_all[35:0] = mkf(2'b00, 26'h11); step();
        chk("bad_vc00_err", err_all[0], 1'b1);
        inj_flit_all[35:0] = mkf(2'b11, 26'h22); step();
        n_wr = 0;
        for (int k = 0; k < 5; k++) begin
            inj_flit_all[35:0] = mkf(2'b10, 26'(k + 'h400));
            step();
        end
        chk("bad_vc_cnt", n_wr, 4);

        // Ejection round-robin
        do_reset();
        flit_in_wr_all[0] = 1'b1; flit_in_all[35:0] = mkf(2'b01, 26'hA0); step();
        flit_in_wr_all[0] = 1'b1; flit_in_all[35:0] = mkf(2'b01, 26'hA1); step();
        flit_in_wr_all[0] = 1'b1; flit_in_all[35:0] = mkf(2'b10, 26'hB0); step();
        flit_in_wr_all[0] = 1'b1; flit_in_all[35:0] = mkf(2'b10, 26'hB1); step();
        ej_ready_all[0] = 1'b1;
        n_pop = 0;
        for (int k = 0; k < 5; k++) step();
        chk("rr_pops", n_pop, 4);
        chk("rr_err", err_all[0], 1'b0);

        // Ejection backpressure, overflow, and push-while-popping a full FIFO
        do_reset();
        for (int k = 0; k < 5; k++) begin
            flit_in_wr_all[0] = 1'b1;
            flit_in_all[35:0] = mkf(2'b10, 26'(k + 'hC0));
            step();
        end
        chk("ovf_err", err_all[0], 1'b1);
        ej_ready_all[0] = 1'b1;
        flit_in_wr_all[0] = 1'b1;
        flit_in_all[35:0] = mkf(2'b10, 26'hC5);
        step();
        ej_ready_all[0] = 1'b0;
        step();
        ej_ready_all[0] = 1'b1;
        n_pop = 0;
        for (int k = 0; k < 5; k++) step();
        chk("ovf_drain", n_pop, 4);

        // Reset mid-traffic on lanes 0 and 2
        do_reset();
        inj_valid_all = 4'b0101;
        inj_flit_all[35:0]   = mkf(2'b01, 26'hD0);
        inj_flit_all[107:72] = mkf(2'b01, 26'hD2);
        flit_in_wr_all = 4'b0101;
        flit_in_all[35:0]    = mkf(2'b10, 26'hE0);
        flit_in_all[107:72]  = mkf(2'b10, 26'hE2);
        step();
        flit_in_wr_all = 4'b0101;
        chk("lane2_wr", flit_out_wr_all[2], 1'b1);
        chk("lane2_ej", ej_valid_all[2], 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_rst_ctl", {flit_out_wr_all, credit_out_all, ej_valid_all, err_all}, '0);
        chk("async_rst_fo", {28'd0, flit_out_all}, '0);
        chk("async_rst_ej", {28'd0, ej_flit_all}, '0);
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        n_wr = 0;
        inj_valid_all[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            inj_flit_all[35:0] = mkf(2'b10, 26'(k + 'hF0));
            step();
        end
        chk("post_rst_cnt", n_wr, 4);
        chk("post_rst_ej_empty", ej_valid_all[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/noc_flat_ep_bridge.md
Name: noc_flat_ep_bridge

Overview:
- Parametrised endpoint-side bridge between NE local cores and the NoC's flattened endpoint vectors (flit, flit_wr and credit per endpoint).
- Injection: converts valid/ready streams into credit-controlled flit writes, with per-VC credit counters.
- Ejection: buffers incoming flits in per-VC FIFOs, returns credits on pop, and round-robins VCs onto a valid/ready output.
- All ports are flat vectors, so the block can be used as a top-level in Verilog or Verilator flows.

Parameters:
- NE, 4, number of endpoints (independent lanes).
- V, 2, virtual channels per endpoint.
- Fw, 36, flit width.
- B, 4, flits per VC: router input depth (initial credits) and ejection FIFO depth per VC.
- VC_LSB, 26, LSB of the one-hot V-bit VC field inside a flit, i.e. bits [VC_LSB+V-1:VC_LSB].

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- inj_flit_all  in  NE*Fw  core-to-NoC flits; lane i = [Fw*(i+1)-1:Fw*i].
- inj_valid_all  in  NE  injection valid.
- inj_ready_all  out  NE  injection ready (combinational).
- flit_out_all  out  NE*Fw  flits to router.
- flit_out_wr_all  out  NE  flit write strobe.
- credit_in_all  in  NE*V  credit pulses from router; lane i = [V*(i+1)-1:V*i].
- flit_in_all  in  NE*Fw  flits from router.
- flit_in_wr_all  in  NE  flit_in write strobe.
- credit_out_all  out  NE*V  credit pulses to router.
- ej_flit_all  out  NE*Fw  ejected flits to core.
- ej_valid_all  out  NE  ejection valid.
- ej_ready_all  in  NE  ejection ready.
- err_all  out  NE  sticky per-lane error flag.

Behaviour:
- Lanes are fully independent; everything below is per lane i.
- Reset (async assert, sync release) values:
  - credit counters = B for every VC;
  - flit_out = 0, flit_out_wr = 0, credit_out = 0;
  - ejection FIFOs empty, ej_valid = 0, ej_flit = 0;
  - round-robin pointer = VC0;
  - err = 0.
  - Reset mid-transfer discards all buffered flits and in-flight strobes.
- Injection:
  - vc = flit[VC_LSB+V-1:VC_LSB].
  - inj_ready = vc is exactly one-hot AND cnt[vc] > 0.
  - Accept = valid & ready.
  - On accept: flit is registered to flit_out, flit_out_wr = 1 in the next cycle (latency 1), and cnt[vc] decrements.
  - flit_out holds its last value when wr = 0.
  - Back-to-back accepts allow one flit per cycle.
- Credit counters (width clog2(B+1)):
  - credit_in[v] increments cnt[v].
  - Simultaneous decrement and increment on the same VC leaves it unchanged.
  - Increment at cnt = B saturates at B and sets err.
- Invalid VC field: valid = 1 with a non-one-hot VC field (zero or multi-hot) is never accepted and sets err. The core must drop or fix the flit.
- Ejection write:
  - On flit_in_wr, the flit is pushed into FIFO[vc], with vc taken from the flit's one-hot field.
  - Push to a full FIFO, or with a non-one-hot VC field, drops the flit and sets err.
- Ejection output:
  - Round-robin arbiter over non-empty FIFOs, starting at the pointer.
  - ej_flit/ej_valid are combinational from the selected FIFO head (no bubble).
  - On ej_valid & ej_ready: pop the winner, then move the pointer to winner+1 mod V.
  - The pointer does not move when nothing is popped.
  - ej_valid = 0 when all FIFOs are empty.
- Credit return: each pop of FIFO[v] produces credit_out[v] = 1 exactly one cycle later (registered pulse, one per pop).
- Same-cycle push and pop:
  - On the same FIFO, both happen; occupancy is unchanged.
  - A push into a full FIFO that is being popped in the same cycle is accepted, not dropped.
- FIFO pointers are clog2(B)-bit and wrap modulo B; occupancy counters are clog2(B+1)-bit.
- err: sticky, cleared only by reset.

Test Plan:
- Credit exhaustion:
  - Stimulus: B = 4, lane 0, continuous valid on VC0 (flit[26] = 1), no credits returned.
  - Required: 4 accepts, flit_out_wr pulses in cycles 1–4, then inj_ready = 0.
  - Then one credit_in[0] pulse → exactly one more accept.
- Simultaneous credit and accept:
  - Stimulus: cnt = 2, accept and credit_in on the same VC in the same cycle.
  - Required: cnt stays 2.
  - Separately, credit_in at cnt = 4 → cnt stays 4 and err_all[0] = 1.
- Invalid VC field:
  - Stimulus: VC field = 2'b00, then 2'b11.
  - Required: inj_ready = 0, no flit_out_wr, err = 1, counters unchanged.
- Ejection round-robin:
  - Stimulus: preload VC0 with A0, A1 and VC1 with B0, B1; hold ej_ready = 1.
  - Required: output order A0, B0, A1, B1.
  - credit_out pulses on bits 0, 1, 0, 1, each one cycle after its pop.
- Ejection backpressure and overflow:
  - Stimulus: ej_ready = 0, write 5 flits to VC1.
  - Required: 4 stored, 5th dropped, err = 1, credit_out = 0.
  - Then write to the full VC1 while popping it in the same cycle → accepted, occupancy stays 4.
- Reset mid-operation and lane isolation:
  - Stimulus: lanes 0 and 2 active with traffic, then assert reset low.
  - Required: all outputs 0 immediately (asynchronously).
  - After release: counters = 4, FIFOs empty, lanes 1 and 3 unaffected throughout.
